// File: rtl/add_arbiter.sv
// Round-robin arbiter that shares one registered adder among four requesters.
// It grants one requester, adds its operands, then holds the result until it is accepted.
module add_arbiter #(
  parameter int unsigned DATAWIDTH = 8
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [3:0]             req,
  input  logic [4*DATAWIDTH-1:0] a_in,
  input  logic [4*DATAWIDTH-1:0] b_in,
  input  logic                   res_ready,
  output logic [3:0]             gnt,
  output logic [DATAWIDTH-1:0]   sum,
  output logic                   carry,
  output logic [1:0]             sum_id,
  output logic                   sum_valid,
  output logic                   busy
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                 state_q;
  logic [1:0]             ptr_q;
  logic [DATAWIDTH-1:0]   a_q, b_q;
  logic [DATAWIDTH-1:0]   a_arr [4];
  logic [DATAWIDTH-1:0]   b_arr [4];
  logic [1:0]             winner;
  logic [DATAWIDTH:0]     sum_full;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a_arr[i] = a_in[i*DATAWIDTH +: DATAWIDTH];
      b_arr[i] = b_in[i*DATAWIDTH +: DATAWIDTH];
    end
  end

  // Scan from the farthest offset down so the set bit closest to ptr wins.
  always_comb begin
    winner = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr_q + 2'(k)]) winner = ptr_q + 2'(k);
    end
  end

  assign sum_full = {1'b0, a_q} + {1'b0, b_q};

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      gnt       <= '0;
      sum       <= '0;
      carry     <= 1'b0;
      sum_id    <= '0;
      sum_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            a_q     <= a_arr[winner];
            b_q     <= b_arr[winner];
            gnt     <= 4'b0001 << winner;
            sum_id  <= winner;
            ptr_q   <= winner + 2'd1;
            busy    <= 1'b1;
            state_q <= StCalc;
          end else begin
            gnt <= '0;
          end
        end
        StCalc: begin
          gnt          <= '0;
          {carry, sum} <= sum_full;
          sum_valid    <= 1'b1;
          state_q      <= StDone;
        end
        StDone: begin
          // sum, carry and sum_id keep their values after acceptance.
          if (res_ready) begin
            sum_valid <= 1'b0;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_add_arbiter.sv
// Randomised and directed bench for add_arbiter against a transaction-level
// model of the rotating-priority pick and unsigned add.
module tb_add_arbiter;

  localparam int unsigned DW = 8;

  logic            Clk;
  logic            Rst;
  logic [3:0]      req;
  logic [4*DW-1:0] a_in;
  logic [4*DW-1:0] b_in;
  logic            res_ready;
  logic [3:0]      gnt;
  logic [DW-1:0]   sum;
  logic            carry;
  logic [1:0]      sum_id;
  logic            sum_valid;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;
  int ptr_m    = 0;

  add_arbiter #(.DATAWIDTH(DW)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .res_ready (res_ready),
    .gnt       (gnt),
    .sum       (sum),
    .carry     (carry),
    .sum_id    (sum_id),
    .sum_valid (sum_valid),
    .busy      (busy)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Rotating priority: first requester at or after ptr_m, wrapping.
  function automatic int pick(input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      if (r[(ptr_m + k) % 4]) return (ptr_m + k) % 4;
    end
    return -1;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_gnt"}, 32'(gnt), 0);
    check_eq({tag, "_sum"}, 32'(sum), 0);
    check_eq({tag, "_carry"}, 32'(carry), 0);
    check_eq({tag, "_sum_id"}, 32'(sum_id), 0);
    check_eq({tag, "_valid"}, 32'(sum_valid), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
  endtask

  // One full transaction: request, grant, result, optional backpressure, accept.
  task automatic do_op(input logic [3:0] r, input logic [4*DW-1:0] av,
                       input logic [4*DW-1:0] bv, input int hold);
    int  w;
    int  s;
    int  es;
    int  ec;
    bit  seen;
    @(posedge Clk); #1;
    req       = r;
    a_in      = av;
    b_in      = bv;
    res_ready = 1'($urandom_range(0, 1));
    w    = pick(r);
    s    = int'(av[w*DW +: DW]) + int'(bv[w*DW +: DW]);
    es   = s % (1 << DW);
    ec   = s >> DW;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk);
      if (gnt != 4'b0) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("gnt", 32'(gnt), 32'(1) << w);
    if (!seen) return;
    ptr_m = (w + 1) % 4;
    check_eq("gnt_valid", 32'(sum_valid), 0);
    check_eq("gnt_busy", 32'(busy), 1);
    @(posedge Clk); #1;
    req       = 4'($urandom);
    res_ready = 1'b0;
    @(negedge Clk);
    check_eq("res_gnt", 32'(gnt), 0);
    check_eq("res_sum", 32'(sum), 32'(es));
    check_eq("res_carry", 32'(carry), 32'(ec));
    check_eq("res_id", 32'(sum_id), 32'(w));
    check_eq("res_valid", 32'(sum_valid), 1);
    check_eq("res_busy", 32'(busy), 1);
    for (int h = 0; h < hold; h++) begin
      @(posedge Clk); #1;
      req = 4'($urandom);
      @(negedge Clk);
      check_eq("hold_gnt", 32'(gnt), 0);
      check_eq("hold_sum", 32'(sum), 32'(es));
      check_eq("hold_carry", 32'(carry), 32'(ec));
      check_eq("hold_id", 32'(sum_id), 32'(w));
      check_eq("hold_valid", 32'(sum_valid), 1);
      check_eq("hold_busy", 32'(busy), 1);
    end
    @(posedge Clk); #1;
    res_ready = 1'b1;
    req       = 4'b0;
    @(negedge Clk);
    check_eq("pre_acc_valid", 32'(sum_valid), 1);
    @(posedge Clk); #1;
    res_ready = 1'($urandom_range(0, 1));
    @(negedge Clk);
    check_eq("acc_valid", 32'(sum_valid), 0);
    check_eq("acc_busy", 32'(busy), 0);
    check_eq("acc_gnt", 32'(gnt), 0);
    check_eq("acc_sum", 32'(sum), 32'(es));
    check_eq("acc_id", 32'(sum_id), 32'(w));
  endtask

  function automatic logic [4*DW-1:0] put(input int idx, input logic [DW-1:0] v);
    logic [4*DW-1:0] x;
    x = 32'($urandom);
    x[idx*DW +: DW] = v;
    return x;
  endfunction

  initial begin
    int last_cyc;
    int cyc;
    int n_gnt;
    req       = 4'b0;
    a_in      = '0;
    b_in      = '0;
    res_ready = 1'b0;
    Rst       = 1'b0;
    #3 Rst = 1'b1;
    #1 check_idle_outputs("reset");

    // Fairness: all four requesting with the consumer always ready.
    req       = 4'hF;
    a_in      = 32'($urandom);
    b_in      = 32'($urandom);
    res_ready = 1'b1;
    @(posedge Clk); #1 Rst = 1'b0;
    n_gnt    = 0;
    last_cyc = 0;
    cyc      = 0;
    while (n_gnt < 5 && cyc < 40) begin
      @(negedge Clk);
      cyc++;
      if (gnt != 4'b0) begin
        check_eq("rr_gnt", 32'(gnt), 32'(1) << pick(4'hF));
        check_eq("rr_id", 32'(sum_id), 32'(pick(4'hF)));
        if (n_gnt > 0) check_eq("rr_spacing", 32'(cyc - last_cyc), 3);
        ptr_m    = (pick(4'hF) + 1) % 4;
        last_cyc = cyc;
        n_gnt++;
        if (n_gnt == 5) begin
          @(posedge Clk); #1 req = 4'b0;
        end
      end
    end
    check_eq("rr_count", 32'(n_gnt), 5);
    repeat (4) @(posedge Clk);

    // Directed single request and overflow corners.
    do_op(4'b0100, put(2, 8'h10), put(2, 8'h25), 0);
    do_op(4'b0001, put(0, 8'hFF), put(0, 8'h01), 0);
    do_op(4'b0001, put(0, 8'h80), put(0, 8'h80), 1);
    do_op(4'b0001, put(0, 8'h7F), put(0, 8'h80), 0);
    // Backpressure, then rotation after requester 1.
    do_op(4'b1010, 32'($urandom), 32'($urandom), 5);
    do_op(4'b0010, 32'($urandom), 32'($urandom), 0);
    do_op(4'b1010, 32'($urandom), 32'($urandom), 2);
    do_op(4'b1010, 32'($urandom), 32'($urandom), 0);

    for (int t = 0; t < 60; t++) begin
      do_op(4'($urandom_range(1, 15)), 32'($urandom), 32'($urandom), $urandom_range(0, 4));
    end

    // Reset while the adder stage is active.
    @(posedge Clk); #1;
    req  = 4'b0100;
    a_in = put(2, 8'h33);
    b_in = put(2, 8'h44);
    res_ready = 1'b1;
    cyc = 0;
    do begin
      @(negedge Clk);
      cyc++;
    end while (gnt == 4'b0 && cyc < 8);
    check_eq("rst_pre_gnt", 32'(gnt), 32'(1) << pick(4'b0100));
    #1 Rst = 1'b1;
    req = 4'b0;
    #1 check_idle_outputs("rst_mid");
    @(posedge Clk); #1 Rst = 1'b0;
    ptr_m = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      check_eq("rst_no_valid", 32'(sum_valid), 0);
    end
    do_op(4'b1001, 32'($urandom), 32'($urandom), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
